// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit and receive blocks.
package uart_pkg;

   localparam int DATA_BITS = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } uart_state_t;

   function automatic int unsigned clks_per_bit(input int unsigned freq, input int unsigned baud);
      return freq / baud;
   endfunction

endpackage

// File: rtl/uart_rx_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input, reset to a chosen level.
module sync_2ff #(
   parameter logic RESET_VAL = 1'b1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d_i,
   output logic q_o
);

   logic meta_q;
   logic sync_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_q <= RESET_VAL;
         sync_q <= RESET_VAL;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with a one-entry valid/ready holding register.
// Handshake: a byte moves to the consumer on any posedge where rx_valid and rx_ready are both 1.
module uart_rx
   import uart_pkg::*;
#(
   parameter int unsigned CLK_FREQ  = 50_000_000,
   parameter int unsigned BAUD_RATE = 115_200
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 rx,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_valid,
   input  logic                 rx_ready,
   output logic                 rx_busy,
   output logic                 rx_frame_err,
   output logic                 rx_overrun
);

   localparam int unsigned CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD_RATE);
   localparam int unsigned HALF_BIT     = CLKS_PER_BIT / 2;
   localparam int          CW           = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] CNT_HALF_END = CW'(HALF_BIT - 1);
   localparam logic [CW-1:0] CNT_BIT_END  = CW'(CLKS_PER_BIT - 1);

   generate
      if (CLKS_PER_BIT < 4) begin : g_rate_check
         $error("uart_rx: CLK_FREQ/BAUD_RATE must be at least 4");
      end
   endgenerate

   logic rx_s;

   sync_2ff #(.RESET_VAL(1'b1)) u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d_i   (rx),
      .q_o   (rx_s)
   );

   uart_state_t          state_q,     state_d;
   logic [CW-1:0]        cnt_q,       cnt_d;
   logic [2:0]           bit_idx_q,   bit_idx_d;
   logic [DATA_BITS-1:0] shreg_q,     shreg_d;
   logic [DATA_BITS-1:0] data_q,      data_d;
   logic                 valid_q,     valid_d;
   logic                 armed_q,     armed_d;
   logic                 frame_err_q, frame_err_d;
   logic                 overrun_q,   overrun_d;
   // rx_s carries the synchronizer's reset value for two cycles after reset;
   // prime_q holds off arming until it reflects the real line.
   logic [1:0]           prime_q,     prime_d;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      bit_idx_d   = bit_idx_q;
      shreg_d     = shreg_q;
      data_d      = data_q;
      valid_d     = valid_q;
      armed_d     = armed_q;
      prime_d     = prime_q;
      frame_err_d = 1'b0;
      overrun_d   = 1'b0;

      if (prime_q != 2'd2) prime_d = prime_q + 2'd1;
      if (valid_q && rx_ready) valid_d = 1'b0;

      case (state_q)
         IDLE: begin
            if (prime_q == 2'd2) begin
               if (rx_s) begin
                  armed_d = 1'b1;
               end else if (armed_q) begin
                  state_d = START;
                  cnt_d   = '0;
               end
            end
         end
         START: begin
            if (cnt_q == CNT_HALF_END) begin
               cnt_d = '0;
               if (!rx_s) begin
                  state_d   = DATA;
                  bit_idx_d = 3'd0;
               end else begin
                  state_d = IDLE;
                  armed_d = 1'b1;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         DATA: begin
            if (cnt_q == CNT_BIT_END) begin
               cnt_d   = '0;
               shreg_d = {rx_s, shreg_q[DATA_BITS-1:1]};
               if (bit_idx_q == 3'd7) state_d = STOP;
               else                   bit_idx_d = bit_idx_q + 3'd1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         STOP: begin
            if (cnt_q == CNT_BIT_END) begin
               cnt_d   = '0;
               state_d = IDLE;
               if (rx_s) begin
                  if (!valid_q || rx_ready) begin
                     data_d  = shreg_q;
                     valid_d = 1'b1;
                  end else begin
                     overrun_d = 1'b1;
                  end
               end else begin
                  frame_err_d = 1'b1;
                  armed_d     = 1'b0;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         bit_idx_q   <= '0;
         shreg_q     <= '0;
         data_q      <= '0;
         valid_q     <= 1'b0;
         armed_q     <= 1'b0;
         frame_err_q <= 1'b0;
         overrun_q   <= 1'b0;
         prime_q     <= 2'd0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         bit_idx_q   <= bit_idx_d;
         shreg_q     <= shreg_d;
         data_q      <= data_d;
         valid_q     <= valid_d;
         armed_q     <= armed_d;
         frame_err_q <= frame_err_d;
         overrun_q   <= overrun_d;
         prime_q     <= prime_d;
      end
   end

   assign rx_data      = data_q;
   assign rx_valid     = valid_q;
   assign rx_busy      = (state_q != IDLE);
   assign rx_frame_err = frame_err_q;
   assign rx_overrun   = overrun_q;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx at 16 clocks per bit.
module tb_uart_rx;

   localparam int unsigned CLK_FREQ  = 1600;
   localparam int unsigned BAUD_RATE = 100;
   localparam int          BIT_CLKS  = 16;
   localparam int          STOP_SAMPLE = 2 + BIT_CLKS / 2 + 9 * BIT_CLKS + 1;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       rx = 1'b1;
   logic       rx_ready = 1'b0;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_busy;
   logic       rx_frame_err;
   logic       rx_overrun;

   int checks = 0;
   int errors = 0;
   int err_cnt = 0;
   int ovr_cnt = 0;
   int exp_err = 0;
   int exp_ovr = 0;
   logic       m_valid = 1'b0;
   logic [7:0] m_data = 8'h00;
   logic [7:0] exp_q[$];
   logic [7:0] acc_q[$];

   uart_rx #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD_RATE)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .rx           (rx),
      .rx_data      (rx_data),
      .rx_valid     (rx_valid),
      .rx_ready     (rx_ready),
      .rx_busy      (rx_busy),
      .rx_frame_err (rx_frame_err),
      .rx_overrun   (rx_overrun)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL timeout: simulation did not complete, got running expected done");
      $fatal(1, "timeout");
   end

   always @(negedge clk) begin
      if (rst_n) begin
         if (rx_frame_err) err_cnt++;
         if (rx_overrun) ovr_cnt++;
         if (rx_valid && rx_ready) acc_q.push_back(rx_data);
      end
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk); #1;
      end
   endtask

   // Drives one frame; rdy_at > 0 raises rx_ready for exactly that cycle.
   task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int rdy_at, input int abort_at);
      logic [10:0] frame;
      frame = {1'b1, stop_bit, b, 1'b0};
      @(posedge clk); #1;
      rx = frame[0];
      for (int c = 1; c <= 10 * BIT_CLKS && c < abort_at; c++) begin
         @(posedge clk); #1;
         rx = frame[4'(c / BIT_CLKS)];
         if (rdy_at > 0 && c == rdy_at) rx_ready = 1'b1;
         else if (rdy_at > 0 && c == rdy_at + 1) rx_ready = 1'b0;
      end
   endtask

   task automatic model_frame(input logic [7:0] b, input logic stop_ok);
      if (!stop_ok)     exp_err++;
      else if (m_valid) exp_ovr++;
      else begin
         m_valid = 1'b1;
         m_data  = b;
      end
   endtask

   task automatic check_state(input string tag);
      @(negedge clk);
      check_eq({tag, "_valid"}, 32'(rx_valid), 32'(m_valid));
      if (m_valid) check_eq({tag, "_data"}, 32'(rx_data), 32'(m_data));
      check_eq({tag, "_ferr"}, 32'(err_cnt), 32'(exp_err));
      check_eq({tag, "_ovr"}, 32'(ovr_cnt), 32'(exp_ovr));
   endtask

   task automatic compare_accepted(input string tag);
      check_eq({tag, "_acc_n"}, 32'(acc_q.size()), 32'(exp_q.size()));
      while (acc_q.size() > 0 && exp_q.size() > 0)
         check_eq({tag, "_acc"}, 32'(acc_q.pop_front()), 32'(exp_q.pop_front()));
   endtask

   task automatic consume(input string tag);
      if (m_valid) exp_q.push_back(m_data);
      m_valid = 1'b0;
      @(posedge clk); #1;
      rx_ready = 1'b1;
      @(posedge clk); #1;
      rx_ready = 1'b0;
      @(negedge clk);
      check_eq({tag, "_drop"}, 32'(rx_valid), 32'(0));
      compare_accepted(tag);
   endtask

   task automatic frame_and_check(input string tag, input logic [7:0] b, input logic stop_ok);
      send_frame(b, stop_ok, 0, 1000);
      model_frame(b, stop_ok);
      idle(4);
      check_state(tag);
   endtask

   initial begin
      logic [7:0] b;
      logic       ok;
      int         busy_seen;

      #12;
      check_eq("rst_data", 32'(rx_data), 32'(0));
      check_eq("rst_valid", 32'(rx_valid), 32'(0));
      check_eq("rst_busy", 32'(rx_busy), 32'(0));
      check_eq("rst_ferr", 32'(rx_frame_err), 32'(0));
      check_eq("rst_ovr", 32'(rx_overrun), 32'(0));
      @(posedge clk); #1;
      rst_n = 1'b1;
      idle(5);

      frame_and_check("t1", 8'h4D, 1'b1);
      idle(10);
      check_state("t1_hold");
      consume("t1");

      frame_and_check("t2_bad", 8'h3C, 1'b0);
      frame_and_check("t2_good", 8'hA5, 1'b1);
      consume("t2");

      @(posedge clk); #1;
      rx = 1'b0;
      idle(4);
      rx = 1'b1;
      @(negedge clk);
      check_eq("t3_busy_start", 32'(rx_busy), 32'(1));
      idle(12);
      @(negedge clk);
      check_eq("t3_busy_abort", 32'(rx_busy), 32'(0));
      check_state("t3");

      send_frame(8'h11, 1'b1, 0, 1000);
      model_frame(8'h11, 1'b1);
      send_frame(8'h22, 1'b1, 0, 1000);
      model_frame(8'h22, 1'b1);
      idle(4);
      check_state("t4");
      consume("t4");

      frame_and_check("t5_first", 8'h11, 1'b1);
      send_frame(8'h22, 1'b1, STOP_SAMPLE - 1, 1000);
      exp_q.push_back(m_data);
      m_data = 8'h22;
      idle(4);
      check_state("t5");
      compare_accepted("t5_mid");
      consume("t5");

      for (int i = 0; i < 20; i++) begin
         b  = 8'($urandom_range(0, 255));
         ok = ($urandom_range(0, 4) != 0);
         frame_and_check("rnd", b, ok);
         if ($urandom_range(0, 1) == 1) consume("rnd");
      end
      consume("rnd_end");

      frame_and_check("t6_pre", 8'($urandom_range(0, 255)), 1'b1);
      send_frame(8'h55, 1'b1, 0, 5 * BIT_CLKS + 6);
      rx    = 1'b0;
      rst_n = 1'b0;
      m_valid = 1'b0;
      m_data  = 8'h00;
      #1;
      check_eq("t6_rst_data", 32'(rx_data), 32'(0));
      check_eq("t6_rst_valid", 32'(rx_valid), 32'(0));
      check_eq("t6_rst_busy", 32'(rx_busy), 32'(0));
      idle(10);
      rst_n = 1'b1;
      busy_seen = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (rx_busy || rx_valid || rx_frame_err) busy_seen++;
      end
      check_eq("t6_no_false_start", 32'(busy_seen), 32'(0));
      @(posedge clk); #1;
      rx = 1'b1;
      idle(5);
      frame_and_check("t6_after", 8'hC3, 1'b1);
      consume("t6");

      compare_accepted("final");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
